bira_sg_scheduler: RTL and testbench
====================================

Name: bira_sg_scheduler

Overview:
- Session controller for the spare-allocation search in the built-in redundancy analyser.
- After the BIST test ends, it resets and steps the signal generator one candidate at a time, hands each DSSS/RLSS candidate to the spare verification checker (SVC), and waits for a verdict.
- It stops on the first passing candidate, on exhaustion, or on abort, and reports the repair solution and status to the top-level BIRA.

Parameters:
- DSSS_W, 8, width of the DSSS candidate vector.
- RLSS_W, 3, width of the RLSS candidate vector.
- TIMEOUT, 15, maximum cycles waited for the SG candidate or the SVC verdict before aborting.
- CNT_W, 7, width of the candidate counter (must hold 105).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a session; ignored unless state is IDLE or DONE.
- spare_struct  in  2  spare structure code (1=S1, 2=S2, 3=S3, 0=invalid); sampled on the accepted start.
- test_end  in  1  level, high when BIST fault collection is complete.
- must_fail  in  1  level, must-repair analysis overflow (unrepairable).
- sg_rst  out  1  reset pulse to the signal generator.
- sg_step  out  1  one-cycle pulse requesting the next candidate (drives the SG step/termination input).
- sg_valid  in  1  SG start_SVC strobe; candidate valid this cycle.
- dsss_in  in  DSSS_W  candidate DSSS from the SG.
- rlss_in  in  RLSS_W  candidate RLSS from the SG.
- svc_start  out  1  one-cycle pulse to the SVC; cand_dsss/cand_rlss are valid with it.
- cand_dsss  out  DSSS_W  registered candidate forwarded to the SVC.
- cand_rlss  out  RLSS_W  registered candidate forwarded to the SVC.
- svc_done  in  1  SVC verdict strobe.
- svc_pass  in  1  verdict; meaningful only when svc_done=1.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high while in DONE.
- repairable  out  1  valid when done=1.
- status  out  2  00 none, 01 repaired, 10 exhausted, 11 aborted.
- sol_dsss  out  DSSS_W  winning DSSS; 0 unless status=01.
- sol_rlss  out  RLSS_W  winning RLSS; 0 unless status=01.
- cand_cnt  out  CNT_W  number of candidates issued to the SVC this session.

Behaviour:
- Reset: all outputs are 0, state=IDLE, and the timer, counter and latched structure are cleared. Reset asserted mid-session discards the session immediately; no done pulse is produced.
- States: IDLE, INIT, WAIT_TEST, STEP, WAIT_CAND, WAIT_VERD, DONE.
- IDLE/DONE + start: latch spare_struct, clear cand_cnt, sol_*, status and repairable, then go to INIT. done drops the cycle after start is accepted.
- INIT: sg_rst=1 for exactly this cycle.
  - If the latched struct is 0, go to DONE with status=11.
  - Otherwise go to WAIT_TEST.
- WAIT_TEST: hold until test_end=1, then go to STEP. No timeout applies in this state.
- STEP: sg_step=1 for this one cycle, clear the timer, go to WAIT_CAND.
- WAIT_CAND: on sg_valid:
  - Register dsss_in/rlss_in into cand_*.
  - Pulse svc_start the next cycle; cand_* are stable from that cycle until the verdict.
  - cand_cnt += 1, clear the timer, go to WAIT_VERD.
  - If dsss_in is all-zero, the SG is exhausted: go to DONE with status=10 and do not count the candidate.
- WAIT_VERD: on svc_done:
  - svc_pass=1: copy cand_* into sol_*, set repairable=1, status=01, go to DONE.
  - svc_pass=0 and cand_cnt equals the limit: go to DONE with status=10. The limit is 70 for S1/S2 and 105 for S3.
  - svc_pass=0 otherwise: go to STEP.
- Timer: increments in WAIT_CAND and WAIT_VERD. On reaching TIMEOUT, go to DONE with status=11.
  - If svc_done or sg_valid arrives in the same cycle the timer expires, the handshake wins over the timeout.
- must_fail=1 in any busy state (INIT through WAIT_VERD) goes to DONE with status=11 next cycle. This takes priority over every other event that cycle, including svc_pass.
- Hold rules:
  - sg_step and svc_start are never high together.
  - At most one candidate is outstanding at any time.
  - Any sg_valid outside WAIT_CAND is ignored.
- Latency: from the STEP cycle to svc_start is at least 2 cycles (step, valid capture, start).
- DONE holds all results stable until the next start or reset.

Test Plan:
- spare_struct=1, start, test_end=1; the SVC fails the first 4 candidates and passes the 5th (dsss 8'hF8) -> sol_dsss=8'hF8, status=01, repairable=1, cand_cnt=5, done=1.
- spare_struct=3; the SVC always fails -> exactly 105 svc_start pulses, then status=10, repairable=0, sol_dsss=0, sol_rlss=0.
- spare_struct=2; the SG never asserts sg_valid after a step -> status=11 exactly TIMEOUT cycles after entering WAIT_CAND, busy=0.
- must_fail rises in the same cycle as svc_done=1 with svc_pass=1 -> status=11, sol_*=0, repairable=0.
- spare_struct=0, start -> one sg_rst pulse, no sg_step, then DONE with status=11.
- Reset asserted during WAIT_VERD, then a new start with struct=1 -> all outputs return to 0, the next session restarts with cand_cnt counting from 1, and a start pulse received while busy is ignored.

Source files
------------

// File: rtl/bira_sg_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bira_sg_scheduler
//  Brief    : Session controller for the BIRA spare-allocation search. Resets
//             and steps the signal generator, forwards each DSSS/RLSS
//             candidate to the spare verification checker and stops on the
//             first pass, on exhaustion or on abort.
//  Revision : 1.0 - initial release
// ============================================================================
module bira_sg_scheduler #(
    parameter int DSSS_W  = 8,
    parameter int RLSS_W  = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        spare_struct,
    input  logic              test_end,
    input  logic              must_fail,
    output logic              sg_rst,
    output logic              sg_step,
    input  logic              sg_valid,
    input  logic [DSSS_W-1:0] dsss_in,
    input  logic [RLSS_W-1:0] rlss_in,
    output logic              svc_start,
    output logic [DSSS_W-1:0] cand_dsss,
    output logic [RLSS_W-1:0] cand_rlss,
    input  logic              svc_done,
    input  logic              svc_pass,
    output logic              busy,
    output logic              done,
    output logic              repairable,
    output logic [1:0]        status,
    output logic [DSSS_W-1:0] sol_dsss,
    output logic [RLSS_W-1:0] sol_rlss,
    output logic [CNT_W-1:0]  cand_cnt
);

    // Timer counts 0..TIMEOUT-1; expiry is detected on the last count.
    localparam int                 c_tmr_w    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);

    localparam logic [1:0] c_st_none     = 2'b00;
    localparam logic [1:0] c_st_repaired = 2'b01;
    localparam logic [1:0] c_st_exhaust  = 2'b10;
    localparam logic [1:0] c_st_abort    = 2'b11;

    localparam logic [CNT_W-1:0] c_limit_s12 = CNT_W'(70);
    localparam logic [CNT_W-1:0] c_limit_s3  = CNT_W'(105);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_WAIT_TEST = 3'd2,
        S_STEP      = 3'd3,
        S_WAIT_CAND = 3'd4,
        S_WAIT_VERD = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [1:0]          r_struct;
    logic [c_tmr_w-1:0]  r_timer;
    logic [CNT_W-1:0]    r_cnt;
    logic [DSSS_W-1:0]   r_cand_dsss;
    logic [RLSS_W-1:0]   r_cand_rlss;
    logic [DSSS_W-1:0]   r_sol_dsss;
    logic [RLSS_W-1:0]   r_sol_rlss;
    logic [1:0]          r_status;
    logic                r_repairable;
    logic                r_svc_start;

    logic                w_busy;
    logic                w_accept;
    logic                w_capture;
    logic                w_timer_clr;
    logic                w_timer_inc;
    logic                w_win;
    logic                w_finish;
    logic [1:0]          w_fin_status;
    logic                w_tmr_exp;
    logic [CNT_W-1:0]    w_limit;

    assign w_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_tmr_exp = (r_timer == c_tmr_last);
    assign w_limit   = (r_struct == 2'd3) ? c_limit_s3 : c_limit_s12;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes; must_fail overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timer_clr  = 1'b0;
        w_timer_inc  = 1'b0;
        w_win        = 1'b0;
        w_finish     = 1'b0;
        w_fin_status = c_st_none;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                if (r_struct == 2'd0) begin
                    w_finish     = 1'b1;
                    w_fin_status = c_st_abort;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_state_nxt  = S_WAIT_TEST;
                end
            end
            S_WAIT_TEST: begin
                if (test_end) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                w_timer_clr = 1'b1;
                w_state_nxt = S_WAIT_CAND;
            end
            S_WAIT_CAND: begin
                // A handshake in the expiry cycle wins over the timeout.
                if (sg_valid) begin
                    if (dsss_in == '0) begin
                        w_finish     = 1'b1;
                        w_fin_status = c_st_exhaust;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_capture    = 1'b1;
                        w_timer_clr  = 1'b1;
                        w_state_nxt  = S_WAIT_VERD;
                    end
                end else if (w_tmr_exp) begin
                    w_finish     = 1'b1;
                    w_fin_status = c_st_abort;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_timer_inc  = 1'b1;
                end
            end
            S_WAIT_VERD: begin
                if (svc_done) begin
                    if (svc_pass) begin
                        w_win        = 1'b1;
                        w_finish     = 1'b1;
                        w_fin_status = c_st_repaired;
                        w_state_nxt  = S_DONE;
                    end else if (r_cnt == w_limit) begin
                        w_finish     = 1'b1;
                        w_fin_status = c_st_exhaust;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_state_nxt  = S_STEP;
                    end
                end else if (w_tmr_exp) begin
                    w_finish     = 1'b1;
                    w_fin_status = c_st_abort;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_timer_inc  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (must_fail && w_busy) begin
            w_capture    = 1'b0;
            w_win        = 1'b0;
            w_timer_clr  = 1'b0;
            w_timer_inc  = 1'b0;
            w_finish     = 1'b1;
            w_fin_status = c_st_abort;
            w_state_nxt  = S_DONE;
        end
    end

    // Session datapath: structure latch, timer, counter, candidate and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_struct     <= 2'd0;
            r_timer      <= '0;
            r_cnt        <= '0;
            r_cand_dsss  <= '0;
            r_cand_rlss  <= '0;
            r_sol_dsss   <= '0;
            r_sol_rlss   <= '0;
            r_status     <= c_st_none;
            r_repairable <= 1'b0;
            r_svc_start  <= 1'b0;
        end else begin
            r_svc_start <= w_capture;

            if (w_accept) begin
                r_struct     <= spare_struct;
                r_cnt        <= '0;
                r_sol_dsss   <= '0;
                r_sol_rlss   <= '0;
                r_status     <= c_st_none;
                r_repairable <= 1'b0;
            end

            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + c_tmr_w'(1);
            end

            if (w_capture) begin
                r_cand_dsss <= dsss_in;
                r_cand_rlss <= rlss_in;
                r_cnt       <= r_cnt + CNT_W'(1);
            end

            if (w_finish) begin
                r_status <= w_fin_status;
            end

            if (w_win) begin
                r_sol_dsss   <= r_cand_dsss;
                r_sol_rlss   <= r_cand_rlss;
                r_repairable <= 1'b1;
            end
        end
    end

    assign sg_rst     = (r_state == S_INIT);
    assign sg_step    = (r_state == S_STEP);
    assign svc_start  = r_svc_start;
    assign cand_dsss  = r_cand_dsss;
    assign cand_rlss  = r_cand_rlss;
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign repairable = r_repairable;
    assign status     = r_status;
    assign sol_dsss   = r_sol_dsss;
    assign sol_rlss   = r_sol_rlss;
    assign cand_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bira_sg_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bira_sg_scheduler
//  Brief    : Self-checking bench for bira_sg_scheduler. Behavioural SG and
//             SVC responders; expected candidates and session results are
//             queued when stimulus is driven and compared on DUT output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bira_sg_scheduler;

    localparam int DSSS_W  = 8;
    localparam int RLSS_W  = 3;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        spare_struct;
    logic              test_end;
    logic              must_fail;
    logic              sg_rst;
    logic              sg_step;
    logic              sg_valid;
    logic [DSSS_W-1:0] dsss_in;
    logic [RLSS_W-1:0] rlss_in;
    logic              svc_start;
    logic [DSSS_W-1:0] cand_dsss;
    logic [RLSS_W-1:0] cand_rlss;
    logic              svc_done;
    logic              svc_pass;
    logic              busy;
    logic              done;
    logic              repairable;
    logic [1:0]        status;
    logic [DSSS_W-1:0] sol_dsss;
    logic [RLSS_W-1:0] sol_rlss;
    logic [CNT_W-1:0]  cand_cnt;

    always #5 clk = ~clk;

    bira_sg_scheduler #(
        .DSSS_W  (DSSS_W),
        .RLSS_W  (RLSS_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .spare_struct (spare_struct),
        .test_end     (test_end),
        .must_fail    (must_fail),
        .sg_rst       (sg_rst),
        .sg_step      (sg_step),
        .sg_valid     (sg_valid),
        .dsss_in      (dsss_in),
        .rlss_in      (rlss_in),
        .svc_start    (svc_start),
        .cand_dsss    (cand_dsss),
        .cand_rlss    (cand_rlss),
        .svc_done     (svc_done),
        .svc_pass     (svc_pass),
        .busy         (busy),
        .done         (done),
        .repairable   (repairable),
        .status       (status),
        .sol_dsss     (sol_dsss),
        .sol_rlss     (sol_rlss),
        .cand_cnt     (cand_cnt)
    );

    typedef struct packed {
        logic [1:0]        status;
        logic              rep;
        logic [DSSS_W-1:0] sd;
        logic [RLSS_W-1:0] sr;
        logic [CNT_W-1:0]  cnt;
    } res_t;

    res_t                     res_q[$];
    logic [DSSS_W+RLSS_W-1:0] cand_q[$];
    int                       n_checks = 0;
    int                       n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DSSS_W-1:0] dsss_of(input int k);
        if (k == 5) return 8'hF8;
        return DSSS_W'((k * 29) % 255 + 1);
    endfunction

    function automatic logic [RLSS_W-1:0] rlss_of(input int k);
        return RLSS_W'(k);
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"},   busy,       0);
        check_eq({tag, "_done"},   done,       0);
        check_eq({tag, "_status"}, status,     0);
        check_eq({tag, "_rep"},    repairable, 0);
        check_eq({tag, "_sol"},    {sol_dsss, sol_rlss}, 0);
        check_eq({tag, "_cnt"},    cand_cnt,   0);
        check_eq({tag, "_pulses"}, {svc_start, sg_rst, sg_step}, 0);
        check_eq({tag, "_cand"},   {cand_dsss, cand_rlss}, 0);
    endtask

    // One session: pass_at/zero_at are 1-based candidate indices (0 = never),
    // rst_at asserts reset at that candidate's svc_start instead of a verdict.
    task automatic run_session(input logic [1:0] st, input int pass_at, input int zero_at,
                               input bit silent, input bit mf_pass, input int rst_at,
                               input bit busy_start);
        res_t                     e;
        int                       limit;
        int                       exp_cnt;
        int                       k;
        int                       cyc;
        int                       step_cyc;
        int                       done_cyc;
        int                       ncand;
        int                       nstart;
        int                       n_rst;
        int                       n_step;
        int                       verd_dly;
        bit                       done_seen;
        bit                       pend;
        bit                       did_rst;
        logic [DSSS_W-1:0]        d;
        logic [RLSS_W-1:0]        r;
        logic [DSSS_W+RLSS_W-1:0] exp_c;
        logic [DSSS_W+RLSS_W-1:0] verd_c;

        // Expected outcome from a walk over the candidate sequence.
        limit   = (st == 2'd3) ? 105 : 70;
        e       = '0;
        exp_cnt = 0;
        if (st == 2'd0 || silent) begin
            e.status = 2'b11;
        end else begin
            k = 1;
            while (1) begin
                if (k == zero_at) begin e.status = 2'b10; break; end
                exp_cnt = k;
                if (k == pass_at) begin
                    if (mf_pass) begin
                        e.status = 2'b11;
                    end else begin
                        e.status = 2'b01;
                        e.rep    = 1'b1;
                        e.sd     = dsss_of(k);
                        e.sr     = rlss_of(k);
                    end
                    break;
                end
                if (k == limit) begin e.status = 2'b10; break; end
                k++;
            end
        end
        e.cnt = CNT_W'(exp_cnt);
        if (rst_at == 0) res_q.push_back(e);

        @(negedge clk);
        spare_struct = st;
        start        = 1'b1;
        test_end     = 1'b0;

        cyc = 0; step_cyc = 0; done_cyc = 0; ncand = 0; nstart = 0;
        n_rst = 0; n_step = 0; verd_dly = -1;
        done_seen = 1'b0; pend = 1'b0; did_rst = 1'b0; verd_c = '0;

        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start     = 1'b0;
            sg_valid  = 1'b0;
            dsss_in   = '0;
            rlss_in   = '0;
            svc_done  = 1'b0;
            svc_pass  = 1'b0;
            must_fail = 1'b0;

            if (cyc == 1) begin
                check_eq("accept_done", done, 0);
                check_eq("accept_busy", busy, 1);
            end
            if (cyc == 4) test_end = 1'b1;
            if (busy_start && cyc == 3) begin
                start        = 1'b1;
                spare_struct = 2'd0;
            end

            if (sg_rst) n_rst++;
            if (sg_step || svc_start) check_eq("step_start_overlap", sg_step & svc_start, 0);

            // SG model: a stray zero candidate in the STEP cycle, real one next.
            if (sg_step) begin
                n_step++;
                step_cyc = cyc;
                if (!silent) begin
                    pend     = 1'b1;
                    sg_valid = 1'b1;
                end
            end else if (pend) begin
                pend = 1'b0;
                ncand++;
                d        = (ncand == zero_at) ? '0 : dsss_of(ncand);
                r        = rlss_of(ncand);
                sg_valid = 1'b1;
                dsss_in  = d;
                rlss_in  = r;
                if (d != '0) cand_q.push_back({d, r});
            end

            // SVC model.
            if (svc_start) begin
                nstart++;
                check_eq("cand_expected", cand_q.size() > 0, 1);
                if (cand_q.size() > 0) begin
                    exp_c = cand_q.pop_front();
                    check_eq("cand", {cand_dsss, cand_rlss}, exp_c);
                    check_eq("cnt_live", cand_cnt, nstart);
                end
                if (rst_at == nstart) begin
                    rst     = 1'b1;
                    did_rst = 1'b1;
                    break;
                end
                verd_dly = nstart % 3;
                verd_c   = {cand_dsss, cand_rlss};
            end
            if (verd_dly == 0) begin
                verd_dly = -1;
                check_eq("cand_hold", {cand_dsss, cand_rlss}, verd_c);
                svc_done  = 1'b1;
                svc_pass  = (nstart == pass_at);
                must_fail = mf_pass && (nstart == pass_at);
            end else if (verd_dly > 0) begin
                verd_dly--;
            end

            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end

        start = 1'b0; sg_valid = 1'b0; svc_done = 1'b0; svc_pass = 1'b0; must_fail = 1'b0;

        if (did_rst) begin
            @(negedge clk);
            rst = 1'b0;
            check_idle("rst_mid");
            return;
        end

        check_eq("done_seen", done_seen, 1);
        if (res_q.size() > 0) e = res_q.pop_front();
        check_eq("status", status,     e.status);
        check_eq("rep",    repairable, e.rep);
        check_eq("sol_d",  sol_dsss,   e.sd);
        check_eq("sol_r",  sol_rlss,   e.sr);
        check_eq("cnt",    cand_cnt,   e.cnt);
        check_eq("busy",   busy,       0);
        check_eq("starts", nstart,     exp_cnt);
        check_eq("sg_rst_n", n_rst,    1);
        if (st == 2'd0) check_eq("sg_step_n", n_step, 0);
        if (silent && done_seen) check_eq("tmo_lat", done_cyc - step_cyc - 1, TIMEOUT);

        repeat (3) @(negedge clk);
        check_eq("hold_done",   done,   1);
        check_eq("hold_status", status, e.status);
        check_eq("hold_sol",    {sol_dsss, sol_rlss}, {e.sd, e.sr});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; spare_struct = 2'd0; test_end = 1'b0;
        must_fail = 1'b0; sg_valid = 1'b0; dsss_in = '0; rlss_in = '0;
        svc_done = 1'b0; svc_pass = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        run_session(2'd1, 5, 0, 1'b0, 1'b0, 0, 1'b0); // pass on 5th (F8)
        run_session(2'd3, 0, 0, 1'b0, 1'b0, 0, 1'b0); // S3 exhausts at 105
        run_session(2'd2, 0, 0, 1'b1, 1'b0, 0, 1'b0); // SG silent -> timeout
        run_session(2'd1, 1, 0, 1'b0, 1'b1, 0, 1'b0); // must_fail beats pass
        run_session(2'd0, 0, 0, 1'b0, 1'b0, 0, 1'b0); // invalid structure
        run_session(2'd2, 0, 3, 1'b0, 1'b0, 0, 1'b0); // SG exhausted (zero DSSS)
        run_session(2'd2, 0, 0, 1'b0, 1'b0, 0, 1'b0); // S2 exhausts at 70
        run_session(2'd1, 0, 0, 1'b0, 1'b0, 2, 1'b0); // reset in WAIT_VERD
        run_session(2'd1, 3, 0, 1'b0, 1'b0, 0, 1'b1); // restart, busy start ignored

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
